// File: rtl/vga_sync_decoder_if.sv
// Video stream into the sync decoder and the recovered timing/lock results out of it.
interface vga_sync_decoder_if;
  logic       in_pixel_enable;
  logic       in_hSync;
  logic       in_vSync;
  logic [7:0] in_VGA_R;
  logic [7:0] in_VGA_G;
  logic [7:0] in_VGA_B;

  logic [9:0]  out_pixelX;
  logic [8:0]  out_pixelY;
  logic        out_active;
  logic        out_locked;
  logic        out_frame_done;
  logic [15:0] out_frame_checksum;
  logic        out_error;
  logic [1:0]  out_error_code;

  modport master (
    output in_pixel_enable, in_hSync, in_vSync, in_VGA_R, in_VGA_G, in_VGA_B,
    input  out_pixelX, out_pixelY, out_active, out_locked, out_frame_done,
           out_frame_checksum, out_error, out_error_code
  );

  modport slave (
    input  in_pixel_enable, in_hSync, in_vSync, in_VGA_R, in_VGA_G, in_VGA_B,
    output out_pixelX, out_pixelY, out_active, out_locked, out_frame_done,
           out_frame_checksum, out_error, out_error_code
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA monitor: rebuilds pixel coordinates from hSync/vSync, checks
// line/frame timing, acquires lock and reports an additive RGB checksum per clean frame.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               in_clock,
  input  logic               in_reset,
  vga_sync_decoder_if.slave  vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0]  H_END   = 10'(H_TOTAL);
  localparam logic [9:0]  V_END   = 10'(V_TOTAL);
  localparam logic [9:0]  HS_C    = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  HE_C    = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  VS_C    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VE_C    = 10'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_next;
  logic        hs_prev, vs_prev;
  logic [9:0]  h_count, v_count, line_cnt;
  logic        err_hist;
  logic [15:0] acc;

  logic        hs_a, vs_a, h_edge, v_edge;
  logic [10:0] h_inc;
  logic        line_short, line_long, line_err, frame_err, clean;
  logic [9:0]  h_next, v_next, lines_inc;
  logic        visible;
  logic [15:0] rgb_sum;
  logic        done_set, err_set;
  logic [1:0]  code_sel;

  always_comb begin
    hs_a       = vid.in_hSync ^ SYNC_ACTIVE_LOW;
    vs_a       = vid.in_vSync ^ SYNC_ACTIVE_LOW;
    h_edge     = hs_a & ~hs_prev;
    v_edge     = vs_a & ~vs_prev;
    h_inc      = {1'b0, h_count} + 11'd1;
    line_short = h_edge & (h_inc < {1'b0, H_END});
    line_long  = ~h_edge & (h_inc == {1'b0, H_END});
    line_err   = line_short | line_long;

    h_next = h_count;
    if (h_edge)             h_next = '0;
    else if (h_count != H_END) h_next = h_count + 10'd1;

    v_next = v_count;
    if (v_edge)                       v_next = '0;
    else if (h_edge && v_count != '1) v_next = v_count + 10'd1;

    // The hSync edge coinciding with a vSync edge closes the old frame's line count.
    lines_inc = line_cnt;
    if (h_edge && line_cnt != '1) lines_inc = line_cnt + 10'd1;
    frame_err = v_edge & (lines_inc != V_END);
    clean     = ~err_hist & ~line_err & ~frame_err;

    visible = (h_next >= HS_C) && (h_next < HE_C) && (v_next >= VS_C) && (v_next < VE_C);
    rgb_sum = {8'd0, vid.in_VGA_R} + {8'd0, vid.in_VGA_G} + {8'd0, vid.in_VGA_B};
    code_sel = frame_err ? 2'b11 : (line_long ? 2'b10 : 2'b01);
  end

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      SEARCH: begin
        if (v_edge) state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (v_edge && clean) begin
          state_next = LOCKED;
          done_set   = 1'b1;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          state_next = SEARCH;
          err_set    = 1'b1;
        end else if (v_edge) begin
          done_set = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset)                 state <= SEARCH;
    else if (vid.in_pixel_enable) state <= state_next;
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      hs_prev                <= 1'b0;
      vs_prev                <= 1'b0;
      h_count                <= '0;
      v_count                <= '0;
      line_cnt               <= '0;
      err_hist               <= 1'b0;
      acc                    <= '0;
      vid.out_pixelX         <= '0;
      vid.out_pixelY         <= '0;
      vid.out_active         <= 1'b0;
      vid.out_locked         <= 1'b0;
      vid.out_frame_done     <= 1'b0;
      vid.out_frame_checksum <= '0;
      vid.out_error          <= 1'b0;
      vid.out_error_code     <= '0;
    end else begin
      vid.out_frame_done <= 1'b0;
      vid.out_error      <= 1'b0;
      if (vid.in_pixel_enable) begin
        hs_prev  <= hs_a;
        vs_prev  <= vs_a;
        h_count  <= h_next;
        v_count  <= v_next;
        line_cnt <= v_edge ? '0 : lines_inc;
        err_hist <= v_edge ? 1'b0 : (err_hist | line_err);
        if (v_edge)       acc <= '0;
        else if (visible) acc <= acc + rgb_sum;
        if (visible) begin
          vid.out_pixelX <= h_next - HS_C;
          vid.out_pixelY <= 9'(v_next - VS_C);
        end
        vid.out_active <= visible & (state_next == LOCKED);
        vid.out_locked <= (state_next == LOCKED);
        if (done_set) begin
          vid.out_frame_checksum <= acc;
          vid.out_frame_done     <= 1'b1;
        end
        if (err_set) begin
          vid.out_error      <= 1'b1;
          vid.out_error_code <= code_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a reduced raster so whole frames stay short.
module tb_vga_sync_decoder;
  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HSY = 3;
  localparam int HB  = 3;
  localparam int VA  = 12;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 2;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int HSO = HSY + HB;
  localparam int VSO = VSY + VB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sync_decoder_if vif ();

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .in_clock(clk),
    .in_reset(rst),
    .vid(vif.slave)
  );

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int gap = 0;
  int rnd_rgb = 0;
  logic [63:0] snap;
  logic [63:0] sb_q[$];

  int m_hprev, m_vprev, m_h, m_v, m_lines, m_hist, m_st, m_acc;
  int m_x, m_y, m_cks, m_code;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int x, input int y, input int act, input int lock,
                                       input int done, input int cks, input int err, input int code);
    return {23'd0, 10'(x), 9'(y), act[0], lock[0], done[0], 16'(cks), err[0], 2'(code)};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {23'd0, vif.out_pixelX, vif.out_pixelY, vif.out_active, vif.out_locked,
            vif.out_frame_done, vif.out_frame_checksum, vif.out_error, vif.out_error_code};
  endfunction

  task automatic model_reset();
    m_hprev = 0; m_vprev = 0; m_h = 0; m_v = 0; m_lines = 0; m_hist = 0; m_st = 0;
    m_acc = 0; m_x = 0; m_y = 0; m_cks = 0; m_code = 0;
  endtask

  // Reference behaviour: state 0 = searching, 1 = acquiring, 2 = locked.
  task automatic model_step(input logic hs, input logic vs, input int r, input int g, input int b,
                            output logic [63:0] exp);
    int ha, va, he, ve, sh, lg, nh, nv, li, fe, clean, vis, nst, done, err;
    ha = (hs == 1'b0); va = (vs == 1'b0);
    he = ha && !m_hprev; ve = va && !m_vprev;
    m_hprev = ha; m_vprev = va;
    sh = he && (m_h + 1 < HT);
    lg = !he && (m_h + 1 == HT);
    nh = he ? 0 : ((m_h < HT) ? m_h + 1 : m_h);
    nv = ve ? 0 : ((he && m_v < 1023) ? m_v + 1 : m_v);
    li = (he && m_lines < 1023) ? m_lines + 1 : m_lines;
    fe = ve && (li != VT);
    clean = !m_hist && !sh && !lg && !fe;
    vis = (nh >= HSO) && (nh < HSO + HA) && (nv >= VSO) && (nv < VSO + VA);
    nst = m_st; done = 0; err = 0;
    if (m_st == 0) begin
      if (ve) nst = 1;
    end else if (m_st == 1) begin
      if (ve && clean) begin nst = 2; done = 1; end
    end else begin
      if (sh || lg || fe) begin
        nst = 0; err = 1;
        m_code = fe ? 3 : (lg ? 2 : 1);
      end else if (ve) done = 1;
    end
    if (done) m_cks = m_acc;
    if (ve) m_acc = 0;
    else if (vis) m_acc = (m_acc + r + g + b) % 65536;
    m_hist = ve ? 0 : (m_hist || sh || lg);
    m_lines = ve ? 0 : li;
    m_h = nh; m_v = nv; m_st = nst;
    if (vis) begin m_x = nh - HSO; m_y = nv - VSO; end
    exp = pack(m_x, m_y, (vis && nst == 2) ? 1 : 0, (nst == 2) ? 1 : 0, done, m_cks, err, m_code);
  endtask

  task automatic strobe(input logic hs, input logic vs);
    logic [7:0] r, g, b;
    logic [63:0] e;
    if (rnd_rgb != 0) begin
      r = 8'($urandom_range(255, 0)); g = 8'($urandom_range(255, 0)); b = 8'($urandom_range(255, 0));
    end else begin
      r = 8'd1; g = 8'd2; b = 8'd3;
    end
    @(negedge clk);
    vif.in_hSync = hs; vif.in_vSync = vs;
    vif.in_VGA_R = r; vif.in_VGA_G = g; vif.in_VGA_B = b;
    vif.in_pixel_enable = 1'b1;
    model_step(hs, vs, int'(r), int'(g), int'(b), e);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    snap = dut_vec();
    vif.in_pixel_enable = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // bad_kind: 1 = that line one strobe short, 2 = hSync withheld on that line.
  task automatic send_frame(input int nlines, input int bad_line, input int bad_kind,
                            input int pr, input int pc, output logic [63:0] probe);
    int len;
    logic hs_on;
    probe = '0;
    for (int v = 0; v < nlines; v++) begin
      len = (v == bad_line && bad_kind == 1) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        hs_on = (h < HSY) && !(v == bad_line && bad_kind == 2);
        strobe(!hs_on, !(v < VSY));
        if (v == pr && h == pc) probe = snap;
      end
    end
  endtask

  always @(posedge clk) begin
    if (vif.in_pixel_enable) begin
      #1;
      if (vif.out_error) err_pulses++;
      if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("sb", dut_vec(), sb_q.pop_front());
    end else begin
      #1;
      check("pulse_idle", {62'd0, vif.out_frame_done, vif.out_error}, 64'd0);
    end
  end

  initial begin
    logic [63:0] p;
    int e0;
    vif.in_pixel_enable = 1'b0;
    vif.in_hSync = 1'b1; vif.in_vSync = 1'b1;
    vif.in_VGA_R = '0; vif.in_VGA_G = '0; vif.in_VGA_B = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", dut_vec(), 64'd0);

    // Clean stream, constant colour, strobe every 4 cycles
    gap = 3; rnd_rgb = 0;
    send_frame(VT, -1, 0, 0, 0, p);
    check("t1_first_vs_lock", {63'd0, p[20]}, 64'd0);
    check("t1_first_vs_done", {63'd0, p[19]}, 64'd0);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t1_lock", {63'd0, p[20]}, 64'd1);
    check("t1_done", {63'd0, p[19]}, 64'd1);
    check("t1_cks", {48'd0, p[18:3]}, 64'((HA * VA * 6) % 65536));
    check("t1_no_err", 64'(err_pulses), 64'd0);

    // Coordinate boundaries, back-to-back strobes, random colour
    gap = 0; rnd_rgb = 1;
    send_frame(VT, -1, 0, VSO, HSO, p);
    check("t2_origin", {40'd0, p[40:31], 5'd0, p[30:22]}, {40'd0, 10'd0, 5'd0, 9'd0});
    check("t2_origin_act", {63'd0, p[21]}, 64'd1);
    send_frame(VT, -1, 0, VSO + VA - 1, HSO + HA - 1, p);
    check("t2_corner", {40'd0, p[40:31], 5'd0, p[30:22]}, {40'd0, 10'(HA - 1), 5'd0, 9'(VA - 1)});
    check("t2_corner_act", {63'd0, p[21]}, 64'd1);
    send_frame(VT, -1, 0, VSO + VA - 1, HSO + HA, p);
    check("t2_past_act", {63'd0, p[21]}, 64'd0);
    check("t2_past_hold", {54'd0, p[40:31]}, 64'(HA - 1));

    // Short line while locked, then relock
    send_frame(VT, 5, 1, 6, 0, p);
    check("t3_err", {61'd0, p[20], p[2], 1'b0}, {61'd0, 1'b0, 1'b1, 1'b0});
    check("t3_code", {62'd0, p[1:0]}, 64'd1);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t3_acq_unlocked", {63'd0, p[20]}, 64'd0);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t3_relock", {62'd0, p[20], p[19]}, 64'd3);

    // hSync withheld for one line
    e0 = err_pulses;
    send_frame(VT, 5, 2, 5, 0, p);
    check("t4_err", {63'd0, p[2]}, 64'd1);
    check("t4_code", {62'd0, p[1:0]}, 64'd2);
    check("t4_once", 64'(err_pulses - e0), 64'd1);
    send_frame(VT, -1, 0, -1, -1, p);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t4_relock", {63'd0, p[20]}, 64'd1);

    // One line missing from a frame: locked and then acquiring
    send_frame(VT - 1, -1, 0, -1, -1, p);
    e0 = err_pulses;
    send_frame(VT - 1, -1, 0, 0, 0, p);
    check("t5_err", {61'd0, p[20], p[19], p[2]}, 64'd1);
    check("t5_code", {62'd0, p[1:0]}, 64'd3);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t5_acq_quiet", {61'd0, p[20], p[19], p[2]}, 64'd0);
    check("t5_one_pulse", 64'(err_pulses - e0), 64'd1);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t5_relock", {62'd0, p[20], p[19]}, 64'd3);

    // Asynchronous reset in the middle of a locked frame
    send_frame(8, -1, 0, -1, -1, p);
    @(negedge clk);
    check("t6_pre_lock", {63'd0, vif.out_locked}, 64'd1);
    #1 rst = 1'b1;
    #1 check("t6_async_reset", dut_vec(), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_frame(VT, -1, 0, VSO, HSO, p);
    check("t6_origin", {40'd0, p[40:31], 5'd0, p[30:22]}, 64'd0);
    check("t6_unlocked_act", {62'd0, p[21], p[20]}, 64'd0);
    send_frame(VT, -1, 0, 0, 0, p);
    check("t6_lock", {62'd0, p[20], p[19]}, 64'd3);

    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
